// File: rtl/axi_pkg.sv
// axi_pkg
// Shared AXI-Lite definitions for the initiator and its helpers.
// Contents:
//   RESP_*            AXI response codes
//   TIMEOUT_RDATA     read data returned when a transaction is abandoned
//   master_state_e    state encoding of the AXI-Lite master FSM
//   respIsErr()       true for any response other than OKAY
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } master_state_e;

  // EXOKAY is not expected on AXI-Lite, so it is reported as an error too.
  function automatic logic respIsErr(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_watchdog.sv
// axi_watchdog
// Cycle counter that flags a bus transaction which has been outstanding
// for TIMEOUT_CYCLES cycles. Only built when AXI_MASTER_TIMEOUT_EN is defined.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   start_i    transaction accepted this cycle; clears the count
//   active_i   a transaction is outstanding; count advances
//   expired_o  the count reaches TIMEOUT_CYCLES at the coming edge
module axi_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic active_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  // Count starts at 0 on state entry and advances once per outstanding cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (start_i) begin
      count_q <= '0;
    end else if (active_i) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Flagging one count early lets the FSM leave on the edge where the
  // count would reach the limit.
  assign expired_o = active_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_lite_master.sv
// axi_lite_master
// Single-outstanding AXI4-Lite initiator. Turns one load/store request into
// an AXI-Lite read or write and returns a one-cycle response pulse.
// Optional feature: define AXI_MASTER_TIMEOUT_EN to abandon a transaction
// after TIMEOUT_CYCLES cycles (rsp_err = 1, rsp_rdata = 32'hDEADBEEF).
// Ports:
//   AXI_ACLK, AXI_ARESET         clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_we/addr/wdata/wstrb      request payload, latched on acceptance
//   rsp_valid/rsp_rdata/rsp_err  one-cycle completion pulse
//   AXI_AW*/W*/B*/AR*/R*         AXI-Lite master channels
module axi_lite_master
  import axi_pkg::*;
#(
  parameter int unsigned AXI_AWIDTH     = 32,
  parameter int unsigned AXI_DWIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AXI_AWIDTH-1:0]   req_addr,
  input  logic [AXI_DWIDTH-1:0]   req_wdata,
  input  logic [AXI_DWIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [AXI_DWIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  output logic                    AXI_AWVALID,
  input  logic                    AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  output logic                    AXI_WVALID,
  input  logic                    AXI_WREADY,
  input  logic [1:0]              AXI_BRESP,
  input  logic                    AXI_BVALID,
  output logic                    AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  output logic                    AXI_ARVALID,
  input  logic                    AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  input  logic [1:0]              AXI_RRESP,
  input  logic                    AXI_RVALID,
  output logic                    AXI_RREADY
);

  master_state_e           state_q;
  logic                    awValid_q, wValid_q, bReady_q, arValid_q, rReady_q;
  logic [AXI_AWIDTH-1:0]   awAddr_q, arAddr_q;
  logic [AXI_DWIDTH-1:0]   wData_q, rspRdata_q;
  logic [AXI_DWIDTH/8-1:0] wStrb_q;
  logic                    rspValid_q, rspErr_q;
  logic                    awDone, wDone, bAccept, rAccept, timeoutHit;

  // A channel counts as done once its VALID has dropped, or when its
  // handshake happens this very cycle; B is only taken once both are done.
  assign awDone  = !awValid_q || AXI_AWREADY;
  assign wDone   = !wValid_q || AXI_WREADY;
  assign bAccept = bReady_q && AXI_BVALID && awDone && wDone;
  assign rAccept = rReady_q && AXI_RVALID;

`ifdef AXI_MASTER_TIMEOUT_EN
  axi_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uWatchdog (
    .clk_i    (AXI_ACLK),
    .rst_i    (AXI_ARESET),
    .start_i  ((state_q == IDLE) && req_valid),
    .active_i ((state_q == WRITE) || (state_q == READ)),
    .expired_o(timeoutHit)
  );
`else
  assign timeoutHit = 1'b0;
`endif

  // Whole controller: every bus and response output is a register so no
  // VALID ever depends combinationally on a READY. The response registers
  // are loaded on the edge that enters RESP, so rsp_valid is high exactly
  // while the FSM sits in RESP.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_q    <= IDLE;
      awValid_q  <= 1'b0;
      wValid_q   <= 1'b0;
      bReady_q   <= 1'b0;
      arValid_q  <= 1'b0;
      rReady_q   <= 1'b0;
      awAddr_q   <= '0;
      arAddr_q   <= '0;
      wData_q    <= '0;
      wStrb_q    <= '0;
      rspValid_q <= 1'b0;
      rspErr_q   <= 1'b0;
      rspRdata_q <= '0;
    end else begin
      rspValid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_we) begin
              awAddr_q  <= req_addr;
              wData_q   <= req_wdata;
              wStrb_q   <= req_wstrb;
              awValid_q <= 1'b1;
              wValid_q  <= 1'b1;
              bReady_q  <= 1'b1;
              state_q   <= WRITE;
            end else begin
              arAddr_q  <= req_addr;
              arValid_q <= 1'b1;
              rReady_q  <= 1'b1;
              state_q   <= READ;
            end
          end
        end
        WRITE: begin
          if (timeoutHit) begin
            awValid_q  <= 1'b0;
            wValid_q   <= 1'b0;
            bReady_q   <= 1'b0;
            rspValid_q <= 1'b1;
            rspErr_q   <= 1'b1;
            rspRdata_q <= AXI_DWIDTH'(TIMEOUT_RDATA);
            state_q    <= RESP;
          end else begin
            if (AXI_AWREADY) awValid_q <= 1'b0;
            if (AXI_WREADY) wValid_q <= 1'b0;
            if (bAccept) begin
              bReady_q   <= 1'b0;
              rspValid_q <= 1'b1;
              rspErr_q   <= respIsErr(AXI_BRESP);
              rspRdata_q <= '0;
              state_q    <= RESP;
            end
          end
        end
        READ: begin
          if (timeoutHit) begin
            arValid_q  <= 1'b0;
            rReady_q   <= 1'b0;
            rspValid_q <= 1'b1;
            rspErr_q   <= 1'b1;
            rspRdata_q <= AXI_DWIDTH'(TIMEOUT_RDATA);
            state_q    <= RESP;
          end else begin
            if (AXI_ARREADY) arValid_q <= 1'b0;
            // RREADY is held until R completes, so a responder that waits
            // for RREADY before granting ARREADY can still make progress.
            if (rAccept) begin
              arValid_q  <= 1'b0;
              rReady_q   <= 1'b0;
              rspValid_q <= 1'b1;
              rspErr_q   <= respIsErr(AXI_RRESP);
              rspRdata_q <= AXI_RDATA;
              state_q    <= RESP;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rspValid_q;
  assign rsp_rdata   = rspRdata_q;
  assign rsp_err     = rspErr_q;
  assign AXI_AWADDR  = awAddr_q;
  assign AXI_AWVALID = awValid_q;
  assign AXI_WDATA   = wData_q;
  assign AXI_WSTRB   = wStrb_q;
  assign AXI_WVALID  = wValid_q;
  assign AXI_BREADY  = bReady_q;
  assign AXI_ARADDR  = arAddr_q;
  assign AXI_ARVALID = arValid_q;
  assign AXI_RREADY  = rReady_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master
// Drives axi_lite_master against a small memory responder with adjustable
// per-channel latencies and response codes. Expected read data comes from a
// word array updated straight from the requests; expected latency comes from
// the responder's configured delays.
// Define AXI_MASTER_TIMEOUT_EN to build the DUT with TIMEOUT_CYCLES = 16 and
// add the silent-responder case.
module tb_axi_lite_master;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 16;
`else
  localparam int unsigned TimeoutCycles = 1024;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWe = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic [3:0]  reqWstrb = '0;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic [31:0] awAddr, wData, arAddr;
  logic [3:0]  wStrb;
  logic        awValid, wValid, bReady, arValid, rReady;
  logic        awReady, wReady, bValid, arReady, rValid;
  logic [1:0]  bResp, rResp;
  logic [31:0] rData;

  always #5 clock = ~clock;

  axi_lite_master #(
    .AXI_AWIDTH(32),
    .AXI_DWIDTH(32),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .AXI_ACLK(clock), .AXI_ARESET(reset),
    .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_wstrb(reqWstrb),
    .rsp_valid(rspValid), .rsp_rdata(rspRdata), .rsp_err(rspErr),
    .AXI_AWADDR(awAddr), .AXI_AWVALID(awValid), .AXI_AWREADY(awReady),
    .AXI_WDATA(wData), .AXI_WSTRB(wStrb), .AXI_WVALID(wValid), .AXI_WREADY(wReady),
    .AXI_BRESP(bResp), .AXI_BVALID(bValid), .AXI_BREADY(bReady),
    .AXI_ARADDR(arAddr), .AXI_ARVALID(arValid), .AXI_ARREADY(arReady),
    .AXI_RDATA(rData), .AXI_RRESP(rResp), .AXI_RVALID(rValid), .AXI_RREADY(rReady)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Responder configuration, set by the stimulus before each request.
  int         awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0;
  logic [1:0] bRespCfg = 2'b00, rRespCfg = 2'b00;
  bit         silent = 1'b0;

  // Responder state.
  logic [31:0] respMem [0:15];
  bit          awCommit, wCommit, bIssued, arCommit, rIssued;
  int          awWait, wWait, bWait, arWait, rWait;
  logic [31:0] awAddrLat, wDataLat, arAddrLat;
  logic [3:0]  wStrbLat;
  logic        awGo, wGo, arGo;
  logic [31:0] arAddrNow;

  // A channel "goes" once its READY has been granted or is granted at this edge.
  always_comb begin
    awGo      = awCommit || (awValid && (awWait >= awDelay));
    wGo       = wCommit || (wValid && (wWait >= wDelay));
    arGo      = arCommit || (arValid && (arWait >= arDelay));
    arAddrNow = arCommit ? arAddrLat : arAddr;
  end

  // Memory responder: each READY rises a configurable number of cycles after
  // its VALID is seen; B and R follow once the address (and data) are granted.
  always @(posedge clock) begin
    if (reset) begin
      awReady <= 1'b0; wReady <= 1'b0; bValid <= 1'b0; bResp <= 2'b00;
      arReady <= 1'b0; rValid <= 1'b0; rData <= '0; rResp <= 2'b00;
      awCommit <= 1'b0; wCommit <= 1'b0; bIssued <= 1'b0;
      arCommit <= 1'b0; rIssued <= 1'b0;
      awWait <= 0; wWait <= 0; bWait <= 0; arWait <= 0; rWait <= 0;
      awAddrLat <= '0; wDataLat <= '0; wStrbLat <= '0; arAddrLat <= '0;
      for (int i = 0; i < 16; i++) respMem[i] <= '0;
    end else if (!silent) begin
      if (awValid && awReady) awReady <= 1'b0;
      else if (awValid && !awCommit) begin
        if (awWait >= awDelay) begin
          awReady <= 1'b1; awCommit <= 1'b1; awAddrLat <= awAddr;
        end else awWait <= awWait + 1;
      end
      if (wValid && wReady) wReady <= 1'b0;
      else if (wValid && !wCommit) begin
        if (wWait >= wDelay) begin
          wReady <= 1'b1; wCommit <= 1'b1; wDataLat <= wData; wStrbLat <= wStrb;
        end else wWait <= wWait + 1;
      end
      if (bValid && bReady) begin
        bValid <= 1'b0;
        if (bResp == 2'b00) begin
          for (int b = 0; b < 4; b++)
            if (wStrbLat[b]) respMem[awAddrLat[5:2]][8*b +: 8] <= wDataLat[8*b +: 8];
        end
        awCommit <= 1'b0; wCommit <= 1'b0; bIssued <= 1'b0;
        awWait <= 0; wWait <= 0; bWait <= 0;
      end else if (awGo && wGo && !bIssued) begin
        if (bWait >= bDelay) begin
          bValid <= 1'b1; bResp <= bRespCfg; bIssued <= 1'b1;
        end else bWait <= bWait + 1;
      end
      if (arValid && arReady) arReady <= 1'b0;
      else if (arValid && !arCommit) begin
        if (arWait >= arDelay) begin
          arReady <= 1'b1; arCommit <= 1'b1; arAddrLat <= arAddr;
        end else arWait <= arWait + 1;
      end
      if (rValid && rReady) begin
        rValid <= 1'b0; arCommit <= 1'b0; rIssued <= 1'b0;
        arWait <= 0; rWait <= 0;
      end else if (arGo && !rIssued) begin
        if (rWait >= rDelay) begin
          rValid <= 1'b1; rData <= respMem[arAddrNow[5:2]]; rResp <= rRespCfg;
          rIssued <= 1'b1;
        end else rWait <= rWait + 1;
      end
    end
  end

  // Protocol monitor: VALIDs held with stable payload until their handshake,
  // dropped right after it, and AW/W raised together. Also counts rsp pulses.
  int          protoErr = 0;
  int          rspCount = 0;
  logic        pRst = 1'b1, pAwv = 1'b0, pAwr = 1'b0, pWv = 1'b0, pWr = 1'b0;
  logic        pArv = 1'b0, pArr = 1'b0;
  logic [31:0] pAwa = '0, pWd = '0, pAra = '0;
  logic [3:0]  pWs = '0;

  always @(negedge clock) begin
    pRst <= reset; pAwv <= awValid; pAwr <= awReady; pAwa <= awAddr;
    pWv <= wValid; pWr <= wReady; pWd <= wData; pWs <= wStrb;
    pArv <= arValid; pArr <= arReady; pAra <= arAddr;
    if (!reset && !pRst) begin
      if ((pAwv && pAwr && awValid) || (pAwv && !pAwr && (!awValid || awAddr !== pAwa)) ||
          (pWv && pWr && wValid) ||
          (pWv && !pWr && (!wValid || wData !== pWd || wStrb !== pWs)) ||
          (pArv && pArr && arValid) || (pArv && !pArr && (!arValid || arAddr !== pAra)) ||
          (awValid && !pAwv && !wValid) || (wValid && !pWv && !awValid))
        protoErr <= protoErr + 1;
    end
    if (rspValid) rspCount <= rspCount + 1;
  end

  // Reference memory, updated from the requests themselves.
  logic [31:0] golden [0:15];

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) golden[i] = '0;
  endtask

  // One request: wait for req_ready, present it for one edge, then check the
  // response pulse against the reference memory and the responder timing.
  task automatic applyStimulus(input string tag, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb);
    int          guard, k, rspBase, protoBase, expLat;
    bit          got;
    logic        expErr;
    logic [31:0] expData;
    expErr  = we ? (bRespCfg != 2'b00) : (rRespCfg != 2'b00);
    expData = we ? 32'h0 : golden[addr[5:2]];
    expLat  = we ? 3 + maxOf(awDelay, wDelay) + bDelay : 3 + arDelay + rDelay;
    guard = 0;
    @(negedge clock);
    while (!reqReady && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    checkOutput({tag, ".reqReady"}, 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqWe = we; reqAddr = addr; reqWdata = wdata; reqWstrb = strb;
    @(posedge clock);
    #1 reqValid = 1'b0;
    rspBase = rspCount;
    protoBase = protoErr;
    k = 0;
    got = 1'b0;
    while (k < 200 && !got) begin
      @(negedge clock);
      k++;
      if (k == 1)
        checkOutput({tag, ".valids"}, we ? 32'({awValid, wValid}) : 32'({arValid, rReady}), 32'd3);
      if (rspValid) got = 1'b1;
    end
    checkOutput({tag, ".rspSeen"}, 32'(got), 32'd1);
    if (got) begin
      checkOutput({tag, ".latency"}, 32'(k), 32'(expLat));
      checkOutput({tag, ".err"}, 32'(rspErr), 32'(expErr));
      checkOutput({tag, ".rdata"}, rspRdata, expData);
    end
    if (we && !expErr)
      for (int b = 0; b < 4; b++)
        if (strb[b]) golden[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
    repeat (3) @(negedge clock);
    checkOutput({tag, ".pulses"}, 32'(rspCount - rspBase), 32'd1);
    checkOutput({tag, ".proto"}, 32'(protoErr - protoBase), 32'd0);
  endtask

  task automatic setDelays(input int aw, input int w, input int b, input int ar, input int r);
    awDelay = aw; wDelay = w; bDelay = b; arDelay = ar; rDelay = r;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 16; i++) golden[i] = '0;
    @(negedge clock);
    checkOutput("reset.outputs",
                32'({awValid, wValid, bReady, arValid, rReady, rspValid, rspErr}), 32'd0);
    checkOutput("reset.buses", awAddr | arAddr | wData | 32'(wStrb) | rspRdata, 32'd0);
    doReset();
    checkOutput("reset.reqReady", 32'(reqReady), 32'd1);

    setDelays(0, 0, 0, 0, 0);
    applyStimulus("wr.cafe", 1'b1, 32'h8, 32'hCAFEBABE, 4'hF);
    applyStimulus("rd.cafe", 1'b0, 32'h8, 32'h0, 4'h0);
    checkOutput("rd.cafe.literal", golden[2], 32'hCAFEBABE);

    applyStimulus("wr.ones", 1'b1, 32'hC, 32'hFFFFFFFF, 4'hF);
    applyStimulus("wr.half", 1'b1, 32'hC, 32'h1234ABCD, 4'h3);
    applyStimulus("rd.half", 1'b0, 32'hC, 32'h0, 4'h0);

    setDelays(0, 2, 0, 0, 0);
    applyStimulus("wr.awFirst", 1'b1, 32'h10, 32'h11112222, 4'hF);
    setDelays(2, 0, 1, 0, 0);
    applyStimulus("wr.wFirst", 1'b1, 32'h14, 32'h33334444, 4'hF);
    setDelays(0, 0, 0, 2, 1);
    applyStimulus("rd.skew", 1'b0, 32'h10, 32'h0, 4'h0);

    setDelays(0, 0, 0, 0, 0);
    rRespCfg = 2'b10;
    applyStimulus("rd.slverr", 1'b0, 32'h14, 32'h0, 4'h0);
    rRespCfg = 2'b00;

    // Reset one cycle after acceptance, with a slow responder.
    setDelays(5, 5, 0, 5, 0);
    @(negedge clock);
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = 32'h20; reqWdata = 32'h5A5A5A5A; reqWstrb = 4'hF;
    @(posedge clock);
    #1 reqValid = 1'b0;
    base = rspCount;
    @(negedge clock);
    checkOutput("midReset.before", 32'({awValid, wValid}), 32'd3);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midReset.valids", 32'({awValid, wValid, bReady}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) golden[i] = '0;
    repeat (10) @(negedge clock);
    checkOutput("midReset.noRsp", 32'(rspCount - base), 32'd0);
    checkOutput("midReset.reqReady", 32'(reqReady), 32'd1);

    for (int n = 0; n < 40; n++) begin
      bit          we;
      logic [31:0] addr;
      setDelays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 3), $urandom_range(0, 2));
      bRespCfg = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rRespCfg = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      we   = 1'($urandom_range(0, 1));
      addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      applyStimulus($sformatf("rand%0d", n), we, addr, $urandom, 4'($urandom_range(0, 15)));
    end
    bRespCfg = 2'b00;
    rRespCfg = 2'b00;

`ifdef AXI_MASTER_TIMEOUT_EN
    begin
      int  k;
      bit  got;
      setDelays(0, 0, 0, 0, 0);
      silent = 1'b1;
      @(negedge clock);
      reqValid = 1'b1; reqWe = 1'b0; reqAddr = 32'h8; reqWstrb = 4'h0;
      @(posedge clock);
      #1 reqValid = 1'b0;
      k = 0;
      got = 1'b0;
      while (k < 100 && !got) begin
        @(negedge clock);
        k++;
        if (rspValid) got = 1'b1;
      end
      checkOutput("timeout.seen", 32'(got), 32'd1);
      checkOutput("timeout.cycle", 32'(k), 32'd17);
      checkOutput("timeout.err", 32'(rspErr), 32'd1);
      checkOutput("timeout.rdata", rspRdata, 32'hDEADBEEF);
      checkOutput("timeout.valids", 32'({arValid, rReady}), 32'd0);
      silent = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput("timeout.reqReady", 32'(reqReady), 32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator that turns single-beat load/store requests from the core's LSU or fetch path into AXI-Lite read or write transactions on the system bus. It is the initiator counterpart of the on-chip memory and peripheral responders. It issues one transaction at a time, follows the full AXI-Lite valid/ready rules, and returns a single-cycle response pulse carrying read data and an error flag.

## Interface
- AXI_AWIDTH, 32, address width on request and AXI sides
- AXI_DWIDTH, 32, data width; strobe width is AXI_DWIDTH/8
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when AXI_MASTER_TIMEOUT_EN is defined
- AXI_ACLK  in  1  the single clock
- AXI_ARESET  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AXI_AWIDTH  byte address, driven onto the bus unchanged
- req_wdata  in  AXI_DWIDTH  write data
- req_wstrb  in  AXI_DWIDTH/8  byte enables
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  AXI_DWIDTH  read data; valid only while rsp_valid is high after a read
- rsp_err  out  1  RESP was non-OKAY, or a timeout occurred
- AXI_AWADDR/AWVALID/AWREADY, AXI_WDATA/WSTRB/WVALID/WREADY, AXI_BRESP/BVALID/BREADY, AXI_ARADDR/ARVALID/ARREADY, AXI_RDATA/RRESP/RVALID/RREADY: standard AXI-Lite, master direction

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- req_ready = (state == IDLE). This is combinational from state only; there is no dependence on req_valid.
- Acceptance in IDLE latches addr, wdata, wstrb and we.
- A write moves to WRITE. A read moves to READ.
- WRITE behaviour:
  - AWVALID and WVALID both rise in the same cycle.
  - Each VALID drops on its own handshake. The other VALID is held until its own handshake completes.
  - BREADY is high for the whole state.
  - BVALID is accepted even if it arrives in the same cycle as the AW/W handshakes.
  - B is accepted only after both AW and W have completed, or in the same cycle they complete.
- READ behaviour:
  - ARVALID and RREADY rise together.
  - RREADY stays high until the R handshake. This keeps the block compatible with responders that gate ARREADY on RREADY.
  - ARVALID drops on the AR handshake.
- Capture and completion:
  - On the B or R handshake, the block captures RDATA (reads only) and sets err = (RESP != 2'b00).
  - It then moves to RESP.
- RESP state lasts exactly one cycle:
  - rsp_valid = 1.
  - rsp_rdata holds the captured data for a read and 0 for a write.
  - The FSM then returns to IDLE.
- There is no backpressure on the response path.
- All AXI VALID outputs are registered and never depend on READY within the same cycle.
- Once a VALID is asserted, its address and data stay stable until its handshake.

## Timing
- Reset values: all VALID and READY outputs 0, AWADDR/ARADDR/WDATA/WSTRB 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, state IDLE. req_ready is 1 in the first cycle after reset.
- Request accepted at edge N: VALIDs are high in cycle N+1.
- Against a responder that sets READY/VALID one cycle after seeing VALID: handshake at edge N+2, rsp_valid in cycle N+3.
- Minimum request-to-request spacing is 4 cycles.
- Reset asserted mid-transaction: at the next edge all VALIDs drop, the FSM goes to IDLE and no rsp_valid is produced. A late BVALID/RVALID from before the reset is ignored because BREADY/RREADY are 0.
- AWREADY and WREADY arriving in different cycles is legal, in either order.

## Configuration
- AXI_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to WRITE/READ and increments every cycle in those states.
  - When it reaches TIMEOUT_CYCLES, all VALIDs and READYs drop, the FSM goes to RESP with rsp_err = 1 and rsp_rdata = 32'hDEADBEEF, and the bus is considered abandoned.
- AXI_MASTER_TIMEOUT_EN undefined: no counter; the block waits indefinitely.

## Structure
- Shared package axi_pkg holds:
  - Response codes RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - The master FSM state enum.
- Sub-module axi_watchdog (counter plus expiry flag) is instantiated only under AXI_MASTER_TIMEOUT_EN.

## Test plan
- Write 0xCAFEBABE, strobe 0xF, addr 0x8, against the team memory responder: AW and W valid together, rsp_valid 3 cycles after acceptance with rsp_err = 0. A subsequent read of 0x8 returns 0xCAFEBABE.
- Write strobe 0x3 with data 0x1234ABCD over 0xFFFFFFFF, then read: rsp_rdata = 0xFFFFABCD.
- Skewed responder with AWREADY 2 cycles before WREADY, then the reverse order: each VALID drops individually and exactly one rsp_valid is produced.
- Responder returns RRESP = 2'b10 on a read: rsp_valid with rsp_err = 1.
- Reset asserted in the cycle after acceptance: VALIDs are 0 at the next edge, no rsp_valid appears, and req_ready = 1 after reset deasserts.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, against a responder that never answers: rsp_valid with rsp_err = 1 and rsp_rdata = 0xDEADBEEF at cycle 17 after the state entry.
